// File: rtl/gp_debounce_pkg.sv
// gp_debounce_pkg: shared types and helpers for the gp_debounce input conditioner.
package gp_debounce_pkg;

   // Debounce FSM encoding: base levels and their "checking" states
   typedef enum logic [1:0] {
      ST_LO     = 2'd0,
      ST_CHK_HI = 2'd1,
      ST_HI     = 2'd2,
      ST_CHK_LO = 2'd3
   } state_t;

   // Largest stability window the counter is ever sized for
   localparam int GP_DEBOUNCE_MAX_CYCLES = 255;

   // Counter width: enough to hold DEBOUNCE_CYCLES-1, never narrower than 1 bit
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/gp_sync.sv
// gp_sync: SYNC_STAGES-deep flop chain that brings an asynchronous pin into clk.
// Asynchronous active-low clear, every stage clears to 0.
module gp_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stage_reg;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         logic stage_in;
         if (gi == 0) begin : g_first
            assign stage_in = d;
         end else begin : g_next
            assign stage_in = stage_reg[gi-1];
         end
         // One synchroniser flop; the first stage is the only sampler of the raw pin
         always_ff @(posedge clk or negedge clr) begin
            if (!clr) stage_reg[gi] <= 1'b0;
            else      stage_reg[gi] <= stage_in;
         end
      end
   endgenerate

   assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/gp_debounce.sv
// gp_debounce: synchronise and debounce a raw pin; q changes only after the new
// level has been stable for DEBOUNCE_CYCLES synchronised clocks.
// Optional macro GP_DEBOUNCE_EDGE_EN enables registered rise/fall pulses;
// without it rise/fall are tied low and no edge registers exist.
module gp_debounce
   import gp_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] LO     = ST_LO;
   localparam logic [1:0] CHK_HI = ST_CHK_HI;
   localparam logic [1:0] HI     = ST_HI;
   localparam logic [1:0] CHK_LO = ST_CHK_LO;

   logic             d_s;
   logic [1:0]       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             q_reg, q_next;

   gp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .clr (clr),
      .d   (d),
      .q   (d_s)
   );

   // Next-state logic: a CHK state either confirms the new level, or falls back on a glitch
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      q_next     = q_reg;
      case (state_reg)
         LO: begin
            q_next = 1'b0;
            if (d_s) begin
               state_next = CHK_HI;
               cnt_next   = '0;
            end
         end
         CHK_HI: begin
            if (!d_s) begin
               state_next = LO;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = HI;
               q_next     = 1'b1;
            end else begin
               // only reached below CNT_LAST, so the counter cannot wrap
               cnt_next = cnt_reg + 1'b1;
            end
         end
         HI: begin
            q_next = 1'b1;
            if (!d_s) begin
               state_next = CHK_LO;
               cnt_next   = '0;
            end
         end
         CHK_LO: begin
            if (d_s) begin
               state_next = HI;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = LO;
               q_next     = 1'b0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = LO;
            cnt_next   = '0;
            q_next     = 1'b0;
         end
      endcase
   end

   // State, counter and output level registers; clear abandons any count in progress
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_reg <= LO;
         cnt_reg   <= '0;
         q_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         q_reg     <= q_next;
      end
   end

   assign q = q_reg;

`ifdef GP_DEBOUNCE_EDGE_EN
   logic rise_reg, fall_reg;

   // Edge pulses registered on the same edge as q, so they line up with the new level
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         rise_reg <= q_next & ~q_reg;
         fall_reg <= ~q_next & q_reg;
      end
   end

   assign rise = rise_reg;
   assign fall = fall_reg;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_gp_debounce.sv
// tb_gp_debounce: scoreboard bench for gp_debounce (honours GP_DEBOUNCE_EDGE_EN).
module tb_gp_debounce;

   localparam int D   = 4;
   localparam int S   = 2;
   localparam int LAT = D + 1 + S;   // edges from capture of a stable level to q change

`ifdef GP_DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic clr = 1'b1;
   logic d   = 1'b0;
   logic q, rise, fall;

   always #5 clk = ~clk;

   gp_debounce #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
      .clk  (clk),
      .clr  (clr),
      .d    (d),
      .q    (q),
      .rise (rise),
      .fall (fall)
   );

   typedef struct {
      bit q;
      bit r;
      bit f;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // reference model: delay line of raw samples plus run length of the opposite level
   bit   m_q;
   int   m_run;
   bit   m_dq[$];

   // scenario bookkeeping
   int   edge_n, q_chg, n_rise, n_fall;
   bit   q_prev;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_q   = 1'b0;
      m_run = 0;
      m_dq.delete();
      for (int i = 0; i < S; i++) m_dq.push_back(1'b0);
   endfunction

   // q adopts a level once the synchronised pin has shown it on D+1 consecutive edges
   function automatic void model_edge(input bit dv, output exp_t e);
      bit ds;
      m_dq.push_back(dv);
      ds  = m_dq.pop_front();
      e.r = 1'b0;
      e.f = 1'b0;
      if (ds != m_q) begin
         m_run++;
         if (m_run == D + 1) begin
            m_q   = ds;
            m_run = 0;
            e.r   = EDGE_EN & ds;
            e.f   = EDGE_EN & ~ds;
         end
      end else begin
         m_run = 0;
      end
      e.q = m_q;
   endfunction

   // Monitor: one scoreboard entry per clock, compared mid-cycle
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("mon_q",    int'(q),    int'(e.q));
         check("mon_rise", int'(rise), int'(e.r));
         check("mon_fall", int'(fall), int'(e.f));
         if (rise && fall) check("mon_excl", 1, 0);
         $display("cyc d=%0b clr=%0b q=%0b rise=%0b fall=%0b exp=%0b/%0b/%0b",
                  d, clr, q, rise, fall, e.q, e.r, e.f);
      end
   end

   task automatic mark();
      edge_n = 0;
      q_chg  = 0;
      n_rise = 0;
      n_fall = 0;
   endtask

   // One clock with clr released; returns at negedge+1
   task automatic step(input bit dv);
      exp_t e;
      d = dv;
      @(posedge clk);
      model_edge(dv, e);
      sb.push_back(e);
      @(negedge clk);
      #1;
      edge_n++;
      if (q !== q_prev) begin
         q_chg  = edge_n;
         q_prev = q;
      end
      if (rise) n_rise++;
      if (fall) n_fall++;
   endtask

   task automatic hold(input bit dv, input int n);
      for (int i = 0; i < n; i++) step(dv);
   endtask

   // Assert clr between edges, verify the immediate clear, hold 3 clocks, release
   task automatic reset_pulse(input string tag);
      exp_t z;
      z.q = 1'b0; z.r = 1'b0; z.f = 1'b0;
      #2 clr = 1'b0;
      #1;
      check({tag, "_q"},     int'(q),    0);
      check({tag, "_rise"},  int'(rise), 0);
      check({tag, "_fall"},  int'(fall), 0);
      check({tag, "_state"}, int'(dut.state_reg), 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         sb.push_back(z);
      end
      @(negedge clk);
      #2 clr = 1'b1;
      model_reset();
      q_prev = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seg;
      bit lvl;
      model_reset();
      q_prev = 1'b0;
      mark();

      // power-on reset with d held high
      d = 1'b1;
      @(negedge clk);
      #1;
      reset_pulse("rst");
      mark();
      hold(1'b1, 12);
      check("rst_lat",  q_chg,  LAT);
      check("rst_rise", n_rise, EDGE_EN ? 1 : 0);

      // clean fall from HI
      mark();
      hold(1'b0, 12);
      check("fall_lat", q_chg,  LAT);
      check("fall_cnt", n_fall, EDGE_EN ? 1 : 0);

      // clean rise from LO
      mark();
      hold(1'b1, 12);
      check("rise_lat", q_chg,  LAT);
      check("rise_cnt", n_rise, EDGE_EN ? 1 : 0);

      // glitch while in HI: 3 low cycles is shorter than the window
      mark();
      hold(1'b0, 3);
      hold(1'b1, 8);
      check("glitch_qchg",  q_chg,  0);
      check("glitch_fall",  n_fall, 0);
      check("glitch_state", int'(dut.state_reg), 2);

      // bounce 1,0,1,0,1 then settle high; capture of the final 1 is edge 5
      hold(1'b0, 12);
      mark();
      step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
      hold(1'b1, 10);
      check("bounce_lat", q_chg,  5 + LAT - 1);
      check("bounce_cnt", n_rise, EDGE_EN ? 1 : 0);

      // reset in CHK_HI with cnt=2 (edge 3 enters CHK_HI, edge 5 reaches cnt=2)
      hold(1'b0, 12);
      hold(1'b1, 5);
      check("mid_state", int'(dut.state_reg), 1);
      check("mid_cnt",   int'(dut.cnt_reg),   2);
      reset_pulse("mid");
      mark();
      hold(1'b1, 12);
      check("mid_lat", q_chg, LAT);

      // random segments of assorted hold lengths, with occasional resets
      for (int k = 0; k < 120; k++) begin
         lvl = 1'($urandom_range(0, 1));
         seg = int'($urandom_range(1, D + 3));
         hold(lvl, seg);
         if ($urandom_range(0, 39) == 0) reset_pulse("rnd_rst");
      end
      hold(d, 12);

      check("sb_drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gp_debounce.md
Name: gp_debounce

Overview:
- Input-conditioning stage placed directly upstream of the GreenPAK4 DFF/latch stages (GP_DFF, GP_DFFR, GP_DFFS, GP_DFFSI, GP_DLATCHS).
- Synchronises an asynchronous, possibly bouncing pin into the clk domain.
- Accepts a level change only after it has been stable for DEBOUNCE_CYCLES clocks.
- Output q is a clean level that drives the d input of the downstream flop stage. Optional rise and fall pulses are provided for edge-triggered consumers.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive synchronised cycles a new level must hold before q changes. Legal range 1..255.
- SYNC_STAGES, 2, number of synchroniser flops. Legal range 2..3.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- clr  input  1  reset, asynchronous, active-low (clr=0 resets immediately, independent of clk).
- d  input  1  raw asynchronous pin level.
- q  output  1  debounced level, registered.
- rise  output  1  one-cycle pulse when q goes 0->1. Constant 0 when the feature is compiled out.
- fall  output  1  one-cycle pulse when q goes 1->0. Constant 0 when the feature is compiled out.

Behaviour:
- Reset (clr=0, asynchronous):
  - sync chain = 0, state = LO, cnt = 0, q = 0, rise = 0, fall = 0.
  - Reset asserted mid-count abandons the count. After release the block restarts in LO.
- Synchroniser: d_s is d delayed through SYNC_STAGES flops. No other logic samples d.
- cnt width is CNT_W = max(1, clog2(DEBOUNCE_CYCLES)). cnt saturates and is never allowed to wrap.
- State machine:
  - LO: q=0. If d_s=1, go to CHK_HI with cnt=0; else stay in LO.
  - CHK_HI: q=0.
    - If d_s=0, go to LO (glitch rejected, no output change).
    - Else if cnt==DEBOUNCE_CYCLES-1, go to HI and set q=1 on the same edge.
    - Else cnt=cnt+1.
  - HI: q=1. If d_s=0, go to CHK_LO with cnt=0.
  - CHK_LO: mirror of CHK_HI with polarities swapped. Exits to HI (glitch) or to LO with q=0.
- Latency:
  - Count edge 1 as the first edge that captures a stable new d.
  - With SYNC_STAGES=2, q changes on edge DEBOUNCE_CYCLES+3.
  - Each additional sync stage adds 1 edge.
- Glitch rule: any return of d_s to the old level while in a CHK state resets the attempt. The count restarts from 0 only when the next opposite level arrives.
- DEBOUNCE_CYCLES=1: a CHK state always exits to the new level on its first edge.
- d toggling every cycle: q never changes, and the FSM alternates between the base state and its CHK state.

Optional Feature:
- Macro: GP_DEBOUNCE_EDGE_EN.
- Defined:
  - rise=1 for exactly the cycle after the edge on which q goes 0->1 (registered, coincident with the new q value).
  - fall behaves the same way for 1->0.
  - rise and fall are never high together.
- Undefined: rise and fall are tied to constant 0. No edge registers are inferred. The port list is unchanged.

Decomposition:
- Package gp_debounce_pkg contains:
  - state enum with 2-bit encoding: LO=0, CHK_HI=1, HI=2, CHK_LO=3;
  - constant GP_DEBOUNCE_MAX_CYCLES=255;
  - function computing CNT_W.
- Sub-module gp_sync: parameterised SYNC_STAGES flop chain with async active-low clr, reset value 0. It is instantiated once.

Test Plan:
- Reset: drive clr=0 with d=1 for 3 cycles, then release -> q=0, rise=0 and fall=0 during reset. With d held at 1, q=1 on edge 7 after release (DEBOUNCE_CYCLES=4, SYNC_STAGES=2).
- Clean rise: d 0->1 before edge 1, held -> q=0 through edge 6, q=1 after edge 7. With GP_DEBOUNCE_EDGE_EN, rise=1 for that single cycle only.
- Glitch reject: from HI, d=0 for 3 cycles then back to 1 -> q stays 1, fall stays 0, and the FSM returns to HI.
- Bounce then settle: d toggles 1,0,1,0,1 on consecutive cycles, then holds 1 -> q rises exactly 7 edges after the final 0->1 capture.
- Async reset mid-count: assert clr=0 between clock edges while in CHK_HI with cnt=2 -> q=0 and state=LO immediately, without waiting for clk. After release, a full 7-edge latency is required again.
- Macro off: repeat the clean-rise and clean-fall scenarios -> q timing identical to macro-on, rise=0 and fall=0 throughout.
